// File: rtl/gelato_types.sv
// Shared gelato scalar types.
// WARP_NUM may be overridden with +define+WARP_NUM=<n> (power of two).
`ifndef WARP_NUM
`define WARP_NUM 32
`endif

package gelato_types;

   localparam int WARP_NUM = `WARP_NUM;
   localparam int WARP_W   = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;

   typedef logic [WARP_W-1:0] warp_num_t;
   typedef logic [31:0]       addr_t;
   typedef logic [3:0]        split_table_num_t;

   function automatic warp_num_t wrap_add(warp_num_t p, int unsigned k);
      int unsigned s;
      s = (int'(p) + k) % WARP_NUM;
      return warp_num_t'(s);
   endfunction

endpackage

// File: rtl/gelato_pctable_fetchskd_if.sv
// PC table -> fetch scheduler bundle: per-warp state plus
// one activation strobe per cycle.
interface gelato_pctable_fetchskd_if;
   import gelato_types::*;

   logic [WARP_NUM-1:0] valid;
   addr_t               pc [WARP_NUM];
   split_table_num_t    split_table_num [WARP_NUM];
   logic                activate_valid;
   warp_num_t           activate_warp_num;

   modport master (
      output valid,
      output pc,
      output split_table_num,
      output activate_valid,
      output activate_warp_num
   );

   modport slave (
      input valid,
      input pc,
      input split_table_num,
      input activate_valid,
      input activate_warp_num
   );

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr wins,
// searching ptr+1 .. ptr+WARP_NUM with wraparound.
module gelato_rr_arbiter
   import gelato_types::*;
(
   input  logic [WARP_NUM-1:0] req,
   input  warp_num_t           ptr,
   output logic                gnt_valid,
   output warp_num_t           gnt_idx
);

   warp_num_t cand;

   // walk backwards so the earliest candidate is the last to write
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = WARP_NUM; i >= 1; i--) begin
         cand = wrap_add(ptr, i);
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/gelato_fetch_skd.sv
// Warp fetch scheduler: ready bits, round-robin pick, 1-entry slot.
// Define GELATO_FETCH_SKD_PERF_EN for issue/stall counters.
module gelato_fetch_skd
   import gelato_types::*;
(
   input  logic                       clk,
   input  logic                       rst,
   gelato_pctable_fetchskd_if.slave   pctable,
   output logic                       fetch_valid,
   input  logic                       fetch_ready,
   output warp_num_t                  fetch_warp_num,
   output addr_t                      fetch_pc,
   output split_table_num_t           fetch_split_table_num,
   input  logic                       flush_valid,
   input  warp_num_t                  flush_warp_num
`ifdef GELATO_FETCH_SKD_PERF_EN
   ,
   output logic [31:0]                perf_issue_cnt,
   output logic [31:0]                perf_stall_cnt
`endif
);

   logic [WARP_NUM-1:0] rdy_q, rdy_d;
   logic                slot_v_q, slot_v_d;
   warp_num_t           slot_warp_q, slot_warp_d;
   addr_t               slot_pc_q, slot_pc_d;
   split_table_num_t    slot_stn_q, slot_stn_d;
   warp_num_t           rr_ptr_q, rr_ptr_d;

   logic [WARP_NUM-1:0] flush_mask, act_mask, sel_mask, req;
   logic                fire, load_en, sel;
   logic                gnt_valid;
   warp_num_t           gnt_idx;

   always_comb begin
      flush_mask = '0;
      act_mask   = '0;
      if (flush_valid)
         flush_mask[flush_warp_num] = 1'b1;
      if (pctable.activate_valid)
         act_mask[pctable.activate_warp_num] = 1'b1;
   end

   assign req = pctable.valid & rdy_q & ~flush_mask;

   gelato_rr_arbiter u_arb (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign fire    = slot_v_q & fetch_ready;
   assign load_en = ~slot_v_q | fire;
   assign sel     = load_en & gnt_valid;

   always_comb begin
      sel_mask = '0;
      if (sel)
         sel_mask[gnt_idx] = 1'b1;
   end

   // activation is applied last so it beats both flush and selection
   always_comb begin
      rdy_d       = (rdy_q & ~flush_mask & ~sel_mask) | act_mask;
      slot_v_d    = slot_v_q;
      slot_warp_d = slot_warp_q;
      slot_pc_d   = slot_pc_q;
      slot_stn_d  = slot_stn_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         slot_v_d = gnt_valid;
         if (gnt_valid) begin
            slot_warp_d = gnt_idx;
            slot_pc_d   = pctable.pc[gnt_idx];
            slot_stn_d  = pctable.split_table_num[gnt_idx];
            rr_ptr_d    = gnt_idx;
         end
      end else if (flush_valid && flush_warp_num == slot_warp_q) begin
         slot_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q       <= '0;
         slot_v_q    <= 1'b0;
         slot_warp_q <= '0;
         slot_pc_q   <= '0;
         slot_stn_q  <= '0;
         rr_ptr_q    <= warp_num_t'(WARP_NUM - 1);
      end else begin
         rdy_q       <= rdy_d;
         slot_v_q    <= slot_v_d;
         slot_warp_q <= slot_warp_d;
         slot_pc_q   <= slot_pc_d;
         slot_stn_q  <= slot_stn_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign fetch_valid           = slot_v_q;
   assign fetch_warp_num        = slot_warp_q;
   assign fetch_pc              = slot_pc_q;
   assign fetch_split_table_num = slot_stn_q;

`ifdef GELATO_FETCH_SKD_PERF_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q + {31'd0, fire};
      stall_cnt_d = stall_cnt_q + {31'd0, slot_v_q & ~fetch_ready};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gelato_fetch_skd.sv
// Directed bench for gelato_fetch_skd with a cycle model
// compared every cycle plus hand-computed spot checks.
module tb_gelato_fetch_skd;
   import gelato_types::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fetch_valid;
   logic             fetch_ready = 1'b0;
   warp_num_t        fetch_warp_num;
   addr_t            fetch_pc;
   split_table_num_t fetch_split_table_num;
   logic             flush_valid = 1'b0;
   warp_num_t        flush_warp_num = '0;
`ifdef GELATO_FETCH_SKD_PERF_EN
   logic [31:0]      perf_issue_cnt;
   logic [31:0]      perf_stall_cnt;
`endif

   gelato_pctable_fetchskd_if pif ();

   gelato_fetch_skd dut (
      .clk                   (clk),
      .rst                   (rst),
      .pctable               (pif),
      .fetch_valid           (fetch_valid),
      .fetch_ready           (fetch_ready),
      .fetch_warp_num        (fetch_warp_num),
      .fetch_pc              (fetch_pc),
      .fetch_split_table_num (fetch_split_table_num),
      .flush_valid           (flush_valid),
      .flush_warp_num        (flush_warp_num)
`ifdef GELATO_FETCH_SKD_PERF_EN
      ,
      .perf_issue_cnt        (perf_issue_cnt),
      .perf_stall_cnt        (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pc_of(int w);
      return 32'h1000 + 32'((w ^ 3) * 16);
   endfunction

   // model state: set of ready warps, pointer, one output slot
   bit          m_rdy [WARP_NUM];
   bit          m_v;
   int          m_w;
   logic [31:0] m_pc;
   logic [3:0]  m_stn;
   int          m_ptr;
   int          m_issue;
   int          m_stall;

   function automatic bit flushed(int w);
      return flush_valid && int'(flush_warp_num) == w;
   endfunction

   always @(posedge clk) begin : model
      int  win;
      bit  can_load;
      if (rst) begin
         foreach (m_rdy[i]) m_rdy[i] = 1'b0;
         m_v = 0; m_w = 0; m_pc = 0; m_stn = 0;
         m_ptr = WARP_NUM - 1;
         m_issue = 0; m_stall = 0;
      end else begin
         can_load = !m_v || fetch_ready;
         if (m_v && fetch_ready) m_issue++;
         if (m_v && !fetch_ready) m_stall++;
         win = -1;
         for (int k = 1; k <= WARP_NUM; k++) begin
            int w;
            w = (m_ptr + k) % WARP_NUM;
            if (win < 0 && pif.valid[w] && m_rdy[w] && !flushed(w))
               win = w;
         end
         if (flush_valid) m_rdy[flush_warp_num] = 1'b0;
         if (can_load) begin
            m_v = (win >= 0);
            if (win >= 0) begin
               m_rdy[win] = 1'b0;
               m_w = win; m_pc = pif.pc[win];
               m_stn = pif.split_table_num[win];
               m_ptr = win;
            end
         end else if (flushed(m_w)) begin
            m_v = 0;
         end
         if (pif.activate_valid) m_rdy[pif.activate_warp_num] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", 32'(fetch_valid), 32'(m_v));
         if (m_v) begin
            check("model_warp", 32'(fetch_warp_num), 32'(m_w));
            check("model_pc", fetch_pc, m_pc);
            check("model_stn", 32'(fetch_split_table_num), 32'(m_stn));
         end
`ifdef GELATO_FETCH_SKD_PERF_EN
         check("model_issue", perf_issue_cnt, 32'(m_issue));
         check("model_stall", perf_stall_cnt, 32'(m_stall));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pif.activate_valid = 1'b0;
      flush_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic act(int w);
      pif.activate_valid    = 1'b1;
      pif.activate_warp_num = warp_num_t'(w);
   endtask

   initial begin
      pif.valid = '1;
      pif.activate_valid = 1'b0;
      pif.activate_warp_num = '0;
      for (int w = 0; w < WARP_NUM; w++) begin
         pif.pc[w] = pc_of(w);
         pif.split_table_num[w] = 4'(w);
      end
      rst = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      check("reset_valid", 32'(fetch_valid), 32'd0);
      check("reset_warp", 32'(fetch_warp_num), 32'd0);
      check("reset_pc", fetch_pc, 32'd0);
      rst = 1'b0;

      // single activation, latency and rdy clear
      act(3);
      tick();
      pif.activate_valid = 1'b0;
      tick();
      check("w3_valid", 32'(fetch_valid), 32'd1);
      check("w3_warp", 32'(fetch_warp_num), 32'd3);
      check("w3_pc", fetch_pc, 32'h1000);
      fetch_ready = 1'b1;
      tick();
      tick();
      check("w3_drained", 32'(fetch_valid), 32'd0);

      // back-to-back grants 0,1,2
      do_reset();
      act(0); tick();
      act(1); tick();
      check("seq_g0", 32'(fetch_warp_num), 32'd0);
      act(2); tick();
      check("seq_g1", 32'(fetch_warp_num), 32'd1);
      pif.activate_valid = 1'b0; tick();
      check("seq_g2", 32'(fetch_warp_num), 32'd2);
      check("seq_g2_v", 32'(fetch_valid), 32'd1);
      tick();
      check("seq_empty", 32'(fetch_valid), 32'd0);

      // stall holds the slot; a waiting warp follows on release
      do_reset();
      fetch_ready = 1'b0;
      act(5); tick();
      pif.activate_valid = 1'b0; tick();
      act(2);
      for (int i = 0; i < 4; i++) begin
         tick();
         pif.activate_valid = 1'b0;
         check("stall_valid", 32'(fetch_valid), 32'd1);
         check("stall_warp", 32'(fetch_warp_num), 32'd5);
         check("stall_pc", fetch_pc, 32'h1060);
      end
`ifdef GELATO_FETCH_SKD_PERF_EN
      check("perf_stall4", perf_stall_cnt, 32'd4);
`endif
      fetch_ready = 1'b1;
      tick();
      check("after_stall", 32'(fetch_warp_num), 32'd2);
`ifdef GELATO_FETCH_SKD_PERF_EN
      check("perf_issue1", perf_issue_cnt, 32'd1);
`endif

      // flush of the stalled slot warp
      do_reset();
      fetch_ready = 1'b0;
      act(5); tick();
      pif.activate_valid = 1'b0; tick();
      flush_valid = 1'b1; flush_warp_num = 5;
      tick();
      flush_valid = 1'b0;
      check("flush_empty", 32'(fetch_valid), 32'd0);
      tick(); tick();
      check("flush_nosel", 32'(fetch_valid), 32'd0);

      // same-cycle flush and activate of warp 7
      do_reset();
      fetch_ready = 1'b1;
      act(7); flush_valid = 1'b1; flush_warp_num = 7;
      tick();
      pif.activate_valid = 1'b0; flush_valid = 1'b0;
      tick();
      check("fa_valid", 32'(fetch_valid), 32'd1);
      check("fa_warp", 32'(fetch_warp_num), 32'd7);

      // re-activation while selected keeps the warp ready
      act(7); tick();
      pif.activate_valid = 1'b0; tick();
      check("react_warp", 32'(fetch_warp_num), 32'd7);
      check("react_valid", 32'(fetch_valid), 32'd1);
      tick();
      check("react_done", 32'(fetch_valid), 32'd0);

      // alternating 1/6, reset mid-stream
      do_reset();
      fetch_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         act((i % 2 == 0) ? 1 : 6);
         tick();
         if (i >= 1 && i <= 4)
            check("alt_grant", 32'(fetch_warp_num),
                  (i % 2 == 1) ? 32'd1 : 32'd6);
      end
      rst = 1'b1;
      tick();
      check("mid_rst", 32'(fetch_valid), 32'd0);
      rst = 1'b0;
      pif.valid[6] = 1'b0;
      act(6); tick();
      act(1); tick();
      pif.activate_valid = 1'b0;
      pif.valid[6] = 1'b1;
      tick();
      check("post_rst_g1", 32'(fetch_warp_num), 32'd1);
      check("post_rst_v", 32'(fetch_valid), 32'd1);
      tick();
      check("post_rst_g6", 32'(fetch_warp_num), 32'd6);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
